// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory sequencer: MIPS load/store opcodes,
// controller state encoding and opcode decode helpers.
package dmem_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_LB  = 6'b100000;
  localparam logic [OP_W-1:0] OP_LH  = 6'b100001;
  localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
  localparam logic [OP_W-1:0] OP_LBU = 6'b100100;
  localparam logic [OP_W-1:0] OP_LHU = 6'b100101;
  localparam logic [OP_W-1:0] OP_SB  = 6'b101000;
  localparam logic [OP_W-1:0] OP_SH  = 6'b101001;
  localparam logic [OP_W-1:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_RD,
    ST_CPU_RD_WAIT,
    ST_CPU_WR,
    ST_DBG_ACC,
    ST_DBG_RD_WAIT,
    ST_DONE
  } state_t;

  // Byte count of an access; 0 marks an opcode that touches no memory.
  function automatic logic [2:0] op_size(input logic [OP_W-1:0] op);
    logic [2:0] n;
    n = 3'd0;
    case (op)
      OP_LB, OP_LBU, OP_SB: n = 3'd1;
      OP_LH, OP_LHU, OP_SH: n = 3'd2;
      OP_LW, OP_SW:         n = 3'd4;
      default:              n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic op_is_load(input logic [OP_W-1:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

endpackage

// File: rtl/dmem_seq_ctrl_if.sv
// Bundle of CPU, debug and memory-side signals around the sequencer.
interface dmem_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              cpu_req;
  logic [5:0]        cpu_op;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_stall;
  logic              cpu_done;
  logic [31:0]       cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [7:0]        dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_valid;
  logic [7:0]        dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  cpu_req, cpu_op, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_done, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_valid, dbg_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_op, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_done, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_valid, dbg_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_load_align.sv
// Turns the four captured little-endian bytes into the load result,
// applying sign or zero extension for sub-word loads.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     lanes,
  output logic [31:0]     rdata
);

  always_comb begin
    rdata = lanes;
    case (op)
      OP_LB:   rdata = {{24{lanes[7]}}, lanes[7:0]};
      OP_LBU:  rdata = {24'd0, lanes[7:0]};
      OP_LH:   rdata = {{16{lanes[15]}}, lanes[15:0]};
      OP_LHU:  rdata = {16'd0, lanes[15:0]};
      default: rdata = lanes;
    endcase
  end

endmodule

// File: rtl/dmem_seq_ctrl.sv
// Sequences MIPS loads/stores one byte per cycle onto a byte-wide
// synchronous memory and arbitrates it against a debug byte port.
module dmem_seq_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic           CLK,
  input  logic           RST_n,
  dmem_seq_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  state_t            state;
  logic [2:0]        idx;
  logic [2:0]        n_bytes;
  logic [31:0]       lanes;
  logic [31:0]       lanes_nx;
  logic [31:0]       rdata_aligned;
  logic [31:0]       cpu_rdata_q;
  logic              cpu_done_q;
  logic              dbg_gnt_q;
  logic              dbg_valid_q;
  logic              dbg_rd;
  logic [7:0]        dbg_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [7:0]        mem_wdata_q;
  logic [CNT_W-1:0]  starve;
  logic [1:0]        cap_lane;
  logic              cap_en;
  logic [2:0]        acc_size;
  logic              acc_load;
  logic              cpu_go;

  assign acc_size = op_size(bus.cpu_op);
  assign acc_load = op_is_load(bus.cpu_op);
  assign cpu_go   = bus.cpu_req && !(bus.dbg_req && (starve == CNT_W'(STARVE_MAX)));

  // Byte k returns two cycles after its address is issued.
  always_comb begin
    lanes_nx = lanes;
    cap_en   = 1'b0;
    cap_lane = 2'd0;
    if (state == ST_CPU_RD && idx >= 3'd2) begin
      cap_en   = 1'b1;
      cap_lane = 2'(idx - 3'd2);
    end else if (state == ST_CPU_RD_WAIT) begin
      cap_en   = 1'b1;
      cap_lane = 2'(n_bytes - 3'd1);
    end
    if (cap_en) lanes_nx[{cap_lane, 3'b000} +: 8] = bus.mem_rdata;
  end

  dmem_load_align u_align (
    .op    (bus.cpu_op),
    .lanes (lanes_nx),
    .rdata (rdata_aligned)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state       <= ST_IDLE;
      idx         <= 3'd0;
      n_bytes     <= 3'd0;
      lanes       <= 32'd0;
      cpu_rdata_q <= 32'd0;
      cpu_done_q  <= 1'b0;
      dbg_gnt_q   <= 1'b0;
      dbg_valid_q <= 1'b0;
      dbg_rd      <= 1'b0;
      dbg_rdata_q <= 8'd0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'd0;
      starve      <= '0;
    end else begin
      cpu_done_q  <= 1'b0;
      dbg_gnt_q   <= 1'b0;
      dbg_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      lanes       <= lanes_nx;
      if (!bus.dbg_req) starve <= '0;

      case (state)
        ST_IDLE: begin
          if (cpu_go) begin
            if (bus.dbg_req) starve <= starve + CNT_W'(1);
            n_bytes <= acc_size;
            idx     <= 3'd1;
            lanes   <= 32'd0;
            if (acc_size == 3'd0) begin
              state      <= ST_DONE;
              cpu_done_q <= 1'b1;
            end else if (acc_load) begin
              state      <= ST_CPU_RD;
              mem_addr_q <= bus.cpu_addr;
            end else begin
              state       <= ST_CPU_WR;
              mem_addr_q  <= bus.cpu_addr;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= bus.cpu_wdata[7:0];
            end
          end else if (bus.dbg_req) begin
            state       <= ST_DBG_ACC;
            mem_addr_q  <= bus.dbg_addr;
            mem_we_q    <= bus.dbg_we;
            mem_wdata_q <= bus.dbg_wdata;
            dbg_gnt_q   <= 1'b1;
            dbg_rd      <= !bus.dbg_we;
            starve      <= '0;
          end
        end
        ST_CPU_RD: begin
          if (idx < n_bytes) begin
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
            idx        <= idx + 3'd1;
          end else begin
            state <= ST_CPU_RD_WAIT;
          end
        end
        ST_CPU_RD_WAIT: begin
          cpu_rdata_q <= rdata_aligned;
          cpu_done_q  <= 1'b1;
          state       <= ST_DONE;
        end
        ST_CPU_WR: begin
          if (idx < n_bytes) begin
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_we_q    <= 1'b1;
            mem_wdata_q <= bus.cpu_wdata[{idx[1:0], 3'b000} +: 8];
            idx         <= idx + 3'd1;
          end else begin
            cpu_done_q <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_DBG_ACC: begin
          dbg_valid_q <= dbg_rd;
          state       <= dbg_rd ? ST_DBG_RD_WAIT : ST_IDLE;
        end
        ST_DBG_RD_WAIT: begin
          dbg_rdata_q <= bus.mem_rdata;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_stall = bus.cpu_req & ~cpu_done_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_gnt   = dbg_gnt_q;
  assign bus.dbg_valid = dbg_valid_q;
  // Read byte arrives from memory in the dbg_valid cycle itself; hold it after.
  assign bus.dbg_rdata = dbg_valid_q ? bus.mem_rdata : dbg_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
// Randomized bench for dmem_seq_ctrl against a transaction-level model:
// expected load values, write streams and debug reads derived from a shadow memory.
module tb_dmem_seq_ctrl;

  localparam int unsigned ADDR_W = 16;
  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001,
                         LHU = 6'b100101, LW = 6'b100011,
                         SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

  typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic is_load; logic [31:0] val; } done_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_en = 1'b0;
  always #5 clk = ~clk;

  dmem_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  dmem_seq_ctrl #(.ADDR_W(ADDR_W), .STARVE_MAX(8)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  wr_t        exp_wr[$];
  done_t      exp_done[$];
  logic [7:0] exp_dbg[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [5:0] ops [9] = '{LB, LBU, LH, LHU, LW, SB, SH, SW, 6'b100010};

  // Synchronous byte RAM: read-before-write, data visible the cycle after.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22;
    mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h84;
    forever begin
      @(posedge clk);
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int unsigned nbytes(input logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    if (op == LW || op == SW) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [5:0] op, input logic [15:0] addr);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < int'(nbytes(op)); k++) w[8*k +: 8] = ref_mem[16'(addr + 16'(k))];
    if (op == LB && w[7])  w = w | 32'hFFFF_FF00;
    if (op == LH && w[15]) w = w | 32'hFFFF_0000;
    return w;
  endfunction

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 16'hFFFC + 16'($urandom_range(0, 7));
    return 16'h0040 + 16'($urandom_range(0, 15));
  endfunction

  // Per-cycle compare of outputs against the queued model expectations.
  wr_t mw; done_t md; logic [7:0] mb;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req & ~bus.cpu_done));
      if (bus.mem_we) begin
        check("write_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          mw = exp_wr.pop_front();
          check("write_addr", 32'(bus.mem_addr), 32'(mw.addr));
          check("write_data", 32'(bus.mem_wdata), 32'(mw.data));
        end
      end
      if (bus.cpu_done) begin
        check("done_expected", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) begin
          md = exp_done.pop_front();
          if (md.is_load) check("load_data", bus.cpu_rdata, md.val);
        end
      end
      if (bus.dbg_valid) begin
        check("dbg_valid_expected", 32'(exp_dbg.size() != 0), 32'd1);
        if (exp_dbg.size() != 0) begin
          mb = exp_dbg.pop_front();
          check("dbg_rdata", 32'(bus.dbg_rdata), 32'(mb));
        end
      end
    end
  end

  task automatic cpu_txn(input logic [5:0] op, input logic [15:0] addr, input logic [31:0] wd,
                         output int done_c, output logic [31:0] rd);
    int n; logic ld; logic st; int exp_c; logic [15:0] a;
    n  = int'(nbytes(op));
    ld = (op == LB || op == LBU || op == LH || op == LHU || op == LW);
    st = (n != 0) && !ld;
    exp_done.push_back({ld, ld ? load_val(op, addr) : 32'd0});
    if (st) begin
      for (int k = 0; k < n; k++) begin
        a = 16'(addr + 16'(k));
        exp_wr.push_back({a, wd[8*k +: 8]});
        ref_mem[a] = wd[8*k +: 8];
      end
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_op = op; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    done_c = -1; rd = 32'd0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ld && c >= 1 && c <= n) check("load_addr", 32'(bus.mem_addr), 32'(16'(addr + 16'(c - 1))));
      if (bus.cpu_done) begin done_c = c; rd = bus.cpu_rdata; break; end
    end
    exp_c = (n == 0) ? 1 : (ld ? n + 2 : n + 1);
    check("done_cycle", 32'(done_c), 32'(exp_c));
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic dbg_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         output logic [7:0] rdv);
    int gc; int vc;
    if (we) begin exp_wr.push_back({addr, wd}); ref_mem[addr] = wd; end
    else exp_dbg.push_back(ref_mem[addr]);
    @(posedge clk); #1;
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
    gc = -1; vc = -1; rdv = 8'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.dbg_gnt && gc < 0) gc = c;
      if (bus.dbg_valid) begin vc = c; rdv = bus.dbg_rdata; end
      if ((we && gc >= 0) || (!we && vc >= 0)) break;
      if (gc == c) begin @(posedge clk); #1; bus.dbg_req = 1'b0; end
    end
    check("dbg_gnt_cycle", 32'(gc), 32'd1);
    if (!we) check("dbg_valid_cycle", 32'(vc), 32'd2);
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_done"},  32'(bus.cpu_done),  32'd0);
    check({tag, "_dbg_gnt"},   32'(bus.dbg_gnt),   32'd0);
    check({tag, "_dbg_valid"}, 32'(bus.dbg_valid), 32'd0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_cpu_rdata"}, bus.cpu_rdata,      32'd0);
    check({tag, "_dbg_rdata"}, 32'(bus.dbg_rdata), 32'd0);
  endtask

  initial begin
    int dc; logic [31:0] rd; logic [7:0] rdv; logic [31:0] w;
    int ndone, d8, d9, gnt_c, gnt_after, bad;
    logic [7:0] old2, old3;
    bus.cpu_req = 1'b0; bus.cpu_op = 6'd0; bus.cpu_addr = 16'd0; bus.cpu_wdata = 32'd0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 16'd0; bus.dbg_wdata = 8'd0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;

    // Directed loads on 11 22 33 84 at 0x0010.
    cpu_txn(LW,  16'h0010, 32'd0, dc, rd); check("lw_lit",  rd, 32'h8433_2211);
    cpu_txn(LB,  16'h0013, 32'd0, dc, rd); check("lb_lit",  rd, 32'hFFFF_FF84);
    cpu_txn(LBU, 16'h0013, 32'd0, dc, rd); check("lbu_lit", rd, 32'h0000_0084);
    cpu_txn(LH,  16'h0012, 32'd0, dc, rd); check("lh_lit",  rd, 32'hFFFF_8433);
    cpu_txn(LHU, 16'h0012, 32'd0, dc, rd); check("lhu_lit", rd, 32'h0000_8433);

    // Store wrapping past the top of the address space.
    cpu_txn(SW, 16'hFFFE, 32'hDEAD_BEEF, dc, rd);
    check("sw_done_lit", 32'(dc), 32'd5);
    check("wrap_FFFE", 32'(mem[16'hFFFE]), 32'hEF);
    check("wrap_FFFF", 32'(mem[16'hFFFF]), 32'hBE);
    check("wrap_0000", 32'(mem[16'h0000]), 32'hAD);
    check("wrap_0001", 32'(mem[16'h0001]), 32'hDE);
    dbg_txn(1'b0, 16'h0001, 8'd0, rdv);
    check("dbg_rd_lit", 32'(rdv), 32'hDE);

    // Starvation: sb held with a pending debug write.
    w = $urandom;
    for (int k = 0; k < 8; k++) begin
      exp_wr.push_back({16'h0100, w[7:0]}); exp_done.push_back({1'b0, 32'd0});
    end
    exp_wr.push_back({16'h0200, w[15:8]});
    exp_wr.push_back({16'h0100, w[7:0]}); exp_done.push_back({1'b0, 32'd0});
    ref_mem[16'h0100] = w[7:0]; ref_mem[16'h0200] = w[15:8];
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_op = SB; bus.cpu_addr = 16'h0100; bus.cpu_wdata = w;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 16'h0200; bus.dbg_wdata = w[15:8];
    ndone = 0; d8 = -1; d9 = -1; gnt_c = -1; gnt_after = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.cpu_done) begin
        ndone++;
        if (ndone == 8) d8 = c;
        if (ndone == 9) begin d9 = c; break; end
      end
      if (bus.dbg_gnt) begin gnt_c = c; gnt_after = ndone; @(posedge clk); #1; bus.dbg_req = 1'b0; end
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    check("starve_d8", 32'(d8), 32'd23);
    check("starve_gnt_cycle", 32'(gnt_c), 32'd25);
    check("starve_gnt_after_dones", 32'(gnt_after), 32'd8);
    check("starve_d9", 32'(d9), 32'd28);

    // Random mix of CPU and debug traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) dbg_txn(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), rdv);
      else cpu_txn(ops[$urandom_range(0, 8)], rand_addr(), $urandom, dc, rd);
    end

    // Reset during cycle 3 of a word store.
    w = $urandom;
    old2 = ref_mem[16'h0302]; old3 = ref_mem[16'h0303];
    exp_wr.push_back({16'h0300, w[7:0]});  ref_mem[16'h0300] = w[7:0];
    exp_wr.push_back({16'h0301, w[15:8]}); ref_mem[16'h0301] = w[15:8];
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_op = SW; bus.cpu_addr = 16'h0300; bus.cpu_wdata = w;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0; bus.cpu_req = 1'b0;
    #1; check("rst_mem_we_async", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");
    repeat (3) @(negedge clk);
    check("rst_byte2_kept", 32'(mem[16'h0302]), 32'(old2));
    check("rst_byte3_kept", 32'(mem[16'h0303]), 32'(old3));
    check("rst_byte0_written", 32'(mem[16'h0300]), 32'(w[7:0]));
    dbg_txn(1'b0, 16'h0301, 8'd0, rdv);
    check("rst_byte1_dbg", 32'(rdv), 32'(w[15:8]));

    repeat (2) @(negedge clk);
    check("writes_left", 32'(exp_wr.size()), 32'd0);
    check("dones_left", 32'(exp_done.size()), 32'd0);
    check("dbg_left", 32'(exp_dbg.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_seq_ctrl.md
# dmem_seq_ctrl

Controller that sequences MIPS load/store instructions onto a single-port, byte-wide data memory, one byte per cycle. It also shares that memory with a byte-wide debug/loader port. It sits between the EX/MEM pipeline register and the data memory, and stalls the pipeline until each multi-byte access completes. Byte order is little-endian: byte k of a word lives at addr+k.

## Interface
Parameters:
- ADDR_W, 16, byte-address width; addresses wrap modulo 2^ADDR_W.
- STARVE_MAX, 8, consecutive CPU transactions allowed while dbg_req is pending before debug is forced.

Ports:
- CLK  in  1  system clock, rising edge. One clock domain.
- RST_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM-stage access request; held until cpu_done.
- cpu_op  in  6  MIPS opcode:
  - loads: lb 100000, lbu 100100, lh 100001, lhu 100101, lw 100011.
  - stores: sb 101000, sh 101001, sw 101011.
- cpu_addr  in  ADDR_W  byte address; held with cpu_req.
- cpu_wdata  in  32  store data; held with cpu_req.
- cpu_stall  out  1  combinational: cpu_req & ~cpu_done.
- cpu_done  out  1  registered one-cycle completion pulse.
- cpu_rdata  out  32  assembled load result; valid while cpu_done=1, otherwise holds its last value.
- dbg_req  in  1  debug byte request; held until dbg_gnt.
- dbg_we  in  1  debug write (1) or read (0).
- dbg_addr  in  ADDR_W  debug byte address.
- dbg_wdata  in  8  debug write byte.
- dbg_gnt  out  1  one-cycle pulse, high in the cycle the debug access drives memory.
- dbg_valid  out  1  one-cycle pulse, high the cycle after a debug read's dbg_gnt.
- dbg_rdata  out  8  debug read byte; valid while dbg_valid=1.
- mem_addr  out  ADDR_W  registered memory address.
- mem_we  out  1  registered byte write enable.
- mem_wdata  out  8  registered write byte.
- mem_rdata  in  8  synchronous read data: address sampled at edge t gives data in the cycle after edge t.

## Operation
- Transfer size N from cpu_op: byte ops 1, halfword ops 2, word ops 4.
- An unrecognised opcode with cpu_req set produces no memory access, and cpu_done pulses the cycle after acceptance.
- FSM states: IDLE, CPU_RD, CPU_RD_WAIT, CPU_WR, DBG_ACC, DBG_RD_WAIT, DONE.
- IDLE:
  - If a CPU request exists and is not forced aside by the starvation rule, go to CPU_RD or CPU_WR.
  - Otherwise, if dbg_req, go to DBG_ACC.
- CPU_RD: issue addresses addr+0 … addr+N−1, one per cycle. Each returned byte k is latched into lane k, bits [8k+7:8k].
- CPU_RD_WAIT: capture the last byte, then go to DONE.
- Load result extension:
  - lb sign-extends from bit 7; lh sign-extends from bit 15.
  - lbu and lhu zero-extend.
- CPU_WR: write byte k = cpu_wdata[8k+7:8k] to addr+k with mem_we=1 for N cycles, then go to DONE.
- DONE: cpu_done=1, then return to IDLE. No request is accepted in DONE.
- DBG_ACC: one memory cycle and dbg_gnt=1.
  - Write: return to IDLE.
  - Read: go to DBG_RD_WAIT, which raises dbg_valid with dbg_rdata=mem_rdata, then returns to IDLE.
- Address arithmetic is ADDR_W bits wide; 0xFFFF+1 wraps to 0x0000.
- Starvation counter:
  - Increments on each accepted CPU transaction while dbg_req=1.
  - Clears on a debug grant or when dbg_req=0.
  - When it equals STARVE_MAX, the debug port wins in IDLE even if cpu_req=1.
- mem_we=0 in every state except CPU_WR and DBG_ACC with dbg_we=1.

## Timing
Cycle 0 is the IDLE cycle in which the request is sampled.
- CPU loads:
  - mem_addr = addr+k in cycle k+1, for k = 0 … N−1.
  - cpu_done in cycle N+2: lb/lbu cycle 3, lh/lhu cycle 4, lw cycle 6.
- CPU stores:
  - mem_we=1 in cycles 1 … N.
  - cpu_done in cycle N+1: sb cycle 2, sh cycle 3, sw cycle 5.
- Debug:
  - dbg_gnt in cycle 1.
  - dbg_valid in cycle 2 (reads only).
- Back-to-back: the earliest next acceptance is the cycle after DONE.
- Reset values: state=IDLE; starvation counter=0; cpu_done, dbg_gnt, dbg_valid, mem_we = 0; mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0.
- Reset mid-transaction:
  - mem_we drops immediately (asynchronously); no further bytes are written.
  - Bytes already written stay in memory; no cpu_done is produced.

## Structure
- Shared package dmem_pkg holds:
  - opcode localparams (OP_LB … OP_SW);
  - the state enum;
  - function op_size(op) returning 0, 1, 2 or 4 (0 for an unrecognised opcode);
  - function op_is_load(op).
- Sub-module dmem_load_align: combinational lane assembly plus sign/zero extension from the four captured bytes and cpu_op, producing the 32-bit cpu_rdata.

## Test plan
- lw at 0x0010, memory holding 11 22 33 84 → mem_addr sequence 0x10–0x13 in cycles 1–4; cpu_done in cycle 6; cpu_rdata=0x84332211; cpu_stall high in cycles 0–5.
- lb at 0x0013 → 0xFFFFFF84. lbu at 0x0013 → 0x00000084. lh at 0x0012 → 0xFFFF8433. lhu at 0x0012 → 0x00008433.
- sw 0xDEADBEEF at 0xFFFE → writes EF@FFFE, BE@FFFF, AD@0000, DE@0001; cpu_done in cycle 5.
- cpu_req held continuously with sb ops while dbg_req=1 → dbg_gnt after the 8th cpu_done; the 9th CPU access starts only after the debug access.
- Debug read at 0x0001 after the sw above → dbg_gnt in cycle 1; dbg_valid in cycle 2 with dbg_rdata=0xDE.
- RST_n low during cycle 3 of an sw → mem_we=0 immediately; only bytes 0–1 written; no cpu_done; after release, outputs at reset values and state=IDLE.
